mmu_req_arbiter: RTL and testbench

- Upstream neighbour of the MMU. Arbitrates two CPU-side requesters onto the MMU's single command port: client 0 is instruction fetch and client 1 is load/store.
- Latches the granted request and holds it stable on the MMU inputs for the whole multi-cycle MMU operation.
- Routes the MMU result back to the owning client.
- Adds round-robin fairness, a privilege filter for MMU_SPAG/MMU_PDIR, and a response timeout.

---
 rtl/mmu_req_arbiter_pkg.sv | 42 ++++
 rtl/mmu_req_arbiter_rr.sv | 17 +
 rtl/mmu_req_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mmu_req_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_req_arbiter_pkg.sv
// Shared MMU command/error codes, arbiter state encodings and the latched
// command record used between the CPU-side clients and the MMU.
// No logic here; constants, types and one decode helper only.
package mmu_req_arbiter_pkg;

  // MMU command codes
  localparam logic [3:0] MMU_NOP   = 4'h0;
  localparam logic [3:0] MMU_READ  = 4'h1;
  localparam logic [3:0] MMU_WRITE = 4'h2;
  localparam logic [3:0] MMU_SPAG  = 4'h3;  // set paging enable
  localparam logic [3:0] MMU_PDIR  = 4'h4;  // set page directory base

  // MMU error codes
  localparam logic [3:0] MMU_NOERR   = 4'h0;
  localparam logic [3:0] MMU_FRPAGE  = 4'h1;  // read fault (page not present)
  localparam logic [3:0] MMU_FWPAGE  = 4'h2;  // write fault (page read-only)
  localparam logic [3:0] MMU_FUPAGE  = 4'h3;  // user access to supervisor page
  localparam logic [3:0] MMU_PRIVERR = 4'hD;  // privileged command from user mode
  localparam logic [3:0] MMU_TMOUT   = 4'hE;  // MMU never answered

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_REJECT = 2'd2,
    ARB_DRAIN  = 2'd3
  } arb_state_t;

  // One client's request as latched onto the MMU command port
  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] vaddr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        user;
  } mmu_cmd_t;

  // Commands that change translation state may only come from kernel mode
  function automatic logic is_priv_cmd(input logic [3:0] cmd);
    return (cmd == MMU_SPAG) || (cmd == MMU_PDIR);
  endfunction

endpackage

// File: rtl/mmu_req_arbiter_rr.sv
// 2-way round-robin picker: on contention the client that did not win last
// time is chosen; a lone requester always wins. Combinational, no state.
// Ports: req[1:0] request vector, last previous winner, grant chosen index.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  // With no request the output is a don't-care; it falls to client 0.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/mmu_req_arbiter.sv
// Arbitrates instruction-fetch (client 0) and load/store (client 1) onto the
// MMU command port, holding the granted command until the MMU answers.
// Latency grant->done: MMU time + 1 (reject 1 cycle, timeout TIMEOUT cycles).
// Backpressure: losing/new requests wait in IDLE; no grant while BUSY/REJECT/DRAIN.
// Ports: i_reqN/i_cmdN/i_vaddrN/i_wdataN/i_sizeN/i_userN client requests,
//        o_doneN/o_rdataN/o_errN client results, o_mmu_* latched MMU command,
//        i_mmu_data/i_mmu_valid/i_mmu_error MMU response.
module mmu_req_arbiter
  import mmu_req_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TCW     = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_req0,
  input  logic [3:0]  i_cmd0,
  input  logic [31:0] i_vaddr0,
  input  logic [31:0] i_wdata0,
  input  logic [1:0]  i_size0,
  input  logic        i_user0,
  output logic        o_done0,
  output logic [31:0] o_rdata0,
  output logic [3:0]  o_err0,

  input  logic        i_req1,
  input  logic [3:0]  i_cmd1,
  input  logic [31:0] i_vaddr1,
  input  logic [31:0] i_wdata1,
  input  logic [1:0]  i_size1,
  input  logic        i_user1,
  output logic        o_done1,
  output logic [31:0] o_rdata1,
  output logic [3:0]  o_err1,

  output logic [31:0] o_mmu_vaddr,
  output logic [31:0] o_mmu_data,
  output logic [1:0]  o_mmu_size,
  output logic [3:0]  o_mmu_cmd,
  output logic        o_mmu_user,
  output logic        o_mmu_valid,
  input  logic [31:0] i_mmu_data,
  input  logic        i_mmu_valid,
  input  logic [3:0]  i_mmu_error
);

  arb_state_t     state, state_d;
  mmu_cmd_t       req_c0, req_c1, req_sel, cmd_q;
  logic           gsel;
  logic           owner;
  logic           last_grant;
  logic [TCW-1:0] cnt;

  logic           do_grant;
  logic           do_finish;
  logic           cnt_inc;
  logic           mmu_valid;
  logic [31:0]    fin_rdata;
  logic [3:0]     fin_err;

  assign req_c0 = '{cmd: i_cmd0, vaddr: i_vaddr0, data: i_wdata0, size: i_size0, user: i_user0};
  assign req_c1 = '{cmd: i_cmd1, vaddr: i_vaddr1, data: i_wdata1, size: i_size1, user: i_user1};

  rr_arb2 u_rr (
    .req   ({i_req1, i_req0}),
    .last  (last_grant),
    .grant (gsel)
  );

  assign req_sel = gsel ? req_c1 : req_c0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ARB_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d   = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    cnt_inc   = 1'b0;
    mmu_valid = 1'b0;
    fin_rdata = '0;
    fin_err   = MMU_NOERR;
    case (state)
      ARB_IDLE: begin
        if (i_req0 || i_req1) begin
          do_grant = 1'b1;
          state_d  = (req_sel.user && is_priv_cmd(req_sel.cmd)) ? ARB_REJECT : ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Drop valid in the response cycle so the MMU does not re-accept
        // the same command when it returns to its receive state.
        mmu_valid = !i_mmu_valid;
        cnt_inc   = 1'b1;
        if (i_mmu_valid) begin
          do_finish = 1'b1;
          fin_rdata = i_mmu_data;
          fin_err   = i_mmu_error;
          state_d   = ARB_IDLE;
        end else if (cnt == TCW'(TIMEOUT - 1)) begin
          do_finish = 1'b1;
          fin_err   = MMU_TMOUT;
          state_d   = ARB_DRAIN;
        end
      end
      ARB_REJECT: begin
        do_finish = 1'b1;
        fin_err   = MMU_PRIVERR;
        state_d   = ARB_IDLE;
      end
      ARB_DRAIN: begin
        // The MMU still owes us a response; swallow it before re-arbitrating.
        if (i_mmu_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign o_mmu_valid = mmu_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_q      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;  // client 0 wins the first contention
      cnt        <= '0;
      o_done0    <= 1'b0;
      o_rdata0   <= '0;
      o_err0     <= '0;
      o_done1    <= 1'b0;
      o_rdata1   <= '0;
      o_err1     <= '0;
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      if (do_grant) begin
        cmd_q      <= req_sel;
        owner      <= gsel;
        last_grant <= gsel;
        cnt        <= '0;
      end else if (cnt_inc) begin
        cnt <= cnt + TCW'(1);
      end
      if (do_finish) begin
        if (owner) begin
          o_done1  <= 1'b1;
          o_rdata1 <= fin_rdata;
          o_err1   <= fin_err;
        end else begin
          o_done0  <= 1'b1;
          o_rdata0 <= fin_rdata;
          o_err0   <= fin_err;
        end
      end
    end
  end

  assign o_mmu_vaddr = cmd_q.vaddr;
  assign o_mmu_data  = cmd_q.data;
  assign o_mmu_size  = cmd_q.size;
  assign o_mmu_cmd   = cmd_q.cmd;
  assign o_mmu_user  = cmd_q.user;

endmodule

// File: tb/tb_mmu_req_arbiter.sv
module tb_mmu_req_arbiter;
  import mmu_req_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, user0, user1;
  logic [3:0]  cmd0, cmd1;
  logic [31:0] vaddr0, vaddr1, wdata0, wdata1;
  logic [1:0]  size0, size1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic [3:0]  err0, err1;
  logic [31:0] mmu_vaddr, mmu_data;
  logic [1:0]  mmu_size;
  logic [3:0]  mmu_cmd;
  logic        mmu_user, mmu_valid;
  logic [31:0] mmu_rdata;
  logic        mmu_rvalid;
  logic [3:0]  mmu_rerr;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mmu_req_arbiter #(.TIMEOUT(8), .TCW(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req0      (req0),
    .i_cmd0      (cmd0),
    .i_vaddr0    (vaddr0),
    .i_wdata0    (wdata0),
    .i_size0     (size0),
    .i_user0     (user0),
    .o_done0     (done0),
    .o_rdata0    (rdata0),
    .o_err0      (err0),
    .i_req1      (req1),
    .i_cmd1      (cmd1),
    .i_vaddr1    (vaddr1),
    .i_wdata1    (wdata1),
    .i_size1     (size1),
    .i_user1     (user1),
    .o_done1     (done1),
    .o_rdata1    (rdata1),
    .o_err1      (err1),
    .o_mmu_vaddr (mmu_vaddr),
    .o_mmu_data  (mmu_data),
    .o_mmu_size  (mmu_size),
    .o_mmu_cmd   (mmu_cmd),
    .o_mmu_user  (mmu_user),
    .o_mmu_valid (mmu_valid),
    .i_mmu_data  (mmu_rdata),
    .i_mmu_valid (mmu_rvalid),
    .i_mmu_error (mmu_rerr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic r, input logic [3:0] c, input logic [31:0] va,
                      input logic [31:0] wd, input logic [1:0] sz, input logic u);
    req0 = r; cmd0 = c; vaddr0 = va; wdata0 = wd; size0 = sz; user0 = u;
  endtask

  task automatic set1(input logic r, input logic [3:0] c, input logic [31:0] va,
                      input logic [31:0] wd, input logic [1:0] sz, input logic u);
    req1 = r; cmd1 = c; vaddr1 = va; wdata1 = wd; size1 = sz; user1 = u;
  endtask

  // Called just after the grant edge. Plays the MMU: response pulse lands so
  // that the done pulse is registered exactly `lat` edges after the grant.
  task automatic mmu_resp(input int lat, input logic [31:0] d, input logic [3:0] e);
    for (int i = 1; i < lat; i++) begin
      step();
      chk("busy_valid", {31'd0, mmu_valid}, 32'd1);
      chk("early_done", {30'd0, done1, done0}, 32'd0);
    end
    mmu_rvalid = 1'b1; mmu_rdata = d; mmu_rerr = e;
    #1;
    chk("valid_drop", {31'd0, mmu_valid}, 32'd0);
    step();
    mmu_rvalid = 1'b0; mmu_rdata = '0; mmu_rerr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b0, MMU_NOP, 32'd0, 32'd0, 2'b00, 1'b0);
    set1(1'b0, MMU_NOP, 32'd0, 32'd0, 2'b00, 1'b0);
    mmu_rvalid = 1'b0; mmu_rdata = '0; mmu_rerr = '0;
    repeat (6) step();
    chk("rst_valid", {31'd0, mmu_valid}, 32'd0);
    chk("rst_done",  {30'd0, done1, done0}, 32'd0);
    chk("rst_vaddr", mmu_vaddr, 32'd0);
    rst_n = 1'b1;
    step();

    // Contention twice in a row: client 0 first, then client 1
    set0(1'b1, MMU_READ, 32'h200, 32'd0, 2'b11, 1'b0);
    set1(1'b1, MMU_READ, 32'h300, 32'd0, 2'b11, 1'b0);
    step();
    chk("t2_g0_vaddr", mmu_vaddr, 32'h200);
    chk("t2_g0_valid", {31'd0, mmu_valid}, 32'd1);
    mmu_resp(4, 32'h1111_0200, MMU_NOERR);
    chk("t2_done0", {31'd0, done0}, 32'd1);
    chk("t2_done1_0", {31'd0, done1}, 32'd0);
    chk("t2_rdata0", rdata0, 32'h1111_0200);
    chk("t2_idle_gap", {31'd0, mmu_valid}, 32'd0);
    req0 = 1'b0;
    step();
    chk("t2_g1_vaddr", mmu_vaddr, 32'h300);
    chk("t2_g1_valid", {31'd0, mmu_valid}, 32'd1);
    chk("t2_done0_pulse", {31'd0, done0}, 32'd0);
    mmu_resp(4, 32'h2222_0300, MMU_NOERR);
    chk("t2_done1", {31'd0, done1}, 32'd1);
    chk("t2_done0_off", {31'd0, done0}, 32'd0);
    chk("t2_rdata1", rdata1, 32'h2222_0300);
    req1 = 1'b0;
    step();

    // Single non-paging read from client 0
    set0(1'b1, MMU_READ, 32'h100, 32'd0, 2'b11, 1'b0);
    step();
    chk("t1_vaddr", mmu_vaddr, 32'h100);
    chk("t1_size", {30'd0, mmu_size}, 32'd3);
    chk("t1_cmd", {28'd0, mmu_cmd}, {28'd0, MMU_READ});
    mmu_resp(4, 32'hCAFE_0100, MMU_NOERR);
    chk("t1_done0", {31'd0, done0}, 32'd1);
    chk("t1_rdata0", rdata0, 32'hCAFE_0100);
    chk("t1_err0", {28'd0, err0}, {28'd0, MMU_NOERR});
    chk("t1_done1", {31'd0, done1}, 32'd0);
    req0 = 1'b0;
    step();
    chk("t1_pulse", {31'd0, done0}, 32'd0);
    chk("t1_hold", rdata0, 32'hCAFE_0100);

    // User-mode MMU_SPAG is rejected without touching the MMU
    set1(1'b1, MMU_SPAG, 32'd0, 32'd1, 2'b11, 1'b1);
    step();
    chk("t3_novalid_a", {31'd0, mmu_valid}, 32'd0);
    chk("t3_nodone", {31'd0, done1}, 32'd0);
    step();
    chk("t3_done1", {31'd0, done1}, 32'd1);
    chk("t3_err1", {28'd0, err1}, {28'd0, MMU_PRIVERR});
    chk("t3_rdata1", rdata1, 32'd0);
    chk("t3_novalid_b", {31'd0, mmu_valid}, 32'd0);
    req1 = 1'b0;
    step();
    chk("t3_pulse", {31'd0, done1}, 32'd0);
    chk("t3_err_hold", {28'd0, err1}, {28'd0, MMU_PRIVERR});

    // Kernel PDIR, kernel SPAG, then user write to read-only page
    set0(1'b1, MMU_PDIR, 32'd0, 32'h2000, 2'b11, 1'b0);
    step();
    chk("t4_pdir_cmd", {28'd0, mmu_cmd}, {28'd0, MMU_PDIR});
    chk("t4_pdir_data", mmu_data, 32'h2000);
    mmu_resp(3, 32'd0, MMU_NOERR);
    chk("t4_pdir_done", {31'd0, done0}, 32'd1);
    req0 = 1'b0;
    step();
    set0(1'b1, MMU_SPAG, 32'd0, 32'd1, 2'b11, 1'b0);
    step();
    chk("t4_spag_valid", {31'd0, mmu_valid}, 32'd1);
    mmu_resp(3, 32'd0, MMU_NOERR);
    chk("t4_spag_done", {31'd0, done0}, 32'd1);
    chk("t4_spag_err", {28'd0, err0}, {28'd0, MMU_NOERR});
    req0 = 1'b0;
    step();
    set1(1'b1, MMU_WRITE, 32'h4000, 32'h55, 2'b11, 1'b1);
    step();
    chk("t4_wr_user", {31'd0, mmu_user}, 32'd1);
    chk("t4_wr_cmd", {28'd0, mmu_cmd}, {28'd0, MMU_WRITE});
    mmu_resp(5, 32'd0, MMU_FWPAGE);
    chk("t4_wr_done", {31'd0, done1}, 32'd1);
    chk("t4_wr_err", {28'd0, err1}, {28'd0, MMU_FWPAGE});
    req1 = 1'b0;
    step();

    // Stalled MMU: timeout after 8 cycles, late pulse drained
    set0(1'b1, MMU_READ, 32'h500, 32'd0, 2'b11, 1'b0);
    step();
    set1(1'b1, MMU_READ, 32'h600, 32'd0, 2'b11, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("t5_wait_done", {31'd0, done0}, 32'd0);
      chk("t5_wait_valid", {31'd0, mmu_valid}, 32'd1);
    end
    step();
    chk("t5_tmo_done", {31'd0, done0}, 32'd1);
    chk("t5_tmo_err", {28'd0, err0}, {28'd0, MMU_TMOUT});
    chk("t5_tmo_rdata", rdata0, 32'd0);
    chk("t5_tmo_valid", {31'd0, mmu_valid}, 32'd0);
    req0 = 1'b0;
    step();
    step();
    chk("t5_drain_valid", {31'd0, mmu_valid}, 32'd0);
    chk("t5_drain_hold", mmu_vaddr, 32'h500);
    mmu_rvalid = 1'b1; mmu_rdata = 32'h0BAD; mmu_rerr = 4'h5;
    step();
    mmu_rvalid = 1'b0; mmu_rdata = '0; mmu_rerr = '0;
    chk("t5_late_done", {30'd0, done1, done0}, 32'd0);
    chk("t5_late_rdata", rdata0, 32'd0);
    chk("t5_late_nogrant", mmu_vaddr, 32'h500);
    step();
    chk("t5_g1_vaddr", mmu_vaddr, 32'h600);
    chk("t5_g1_valid", {31'd0, mmu_valid}, 32'd1);
    mmu_resp(4, 32'h6666, MMU_NOERR);
    chk("t5_g1_done", {31'd0, done1}, 32'd1);
    chk("t5_g1_rdata", rdata1, 32'h6666);
    req1 = 1'b0;
    step();

    // Reset while BUSY on a client-0 command, then contention
    set0(1'b1, MMU_READ, 32'h700, 32'd0, 2'b11, 1'b0);
    step();
    step();
    chk("t6_busy", {31'd0, mmu_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, mmu_valid}, 32'd0);
    chk("t6_rst_vaddr", mmu_vaddr, 32'd0);
    chk("t6_rst_cmd", {28'd0, mmu_cmd}, 32'd0);
    chk("t6_rst_rdata1", rdata1, 32'd0);
    chk("t6_rst_err0", {28'd0, err0}, 32'd0);
    mmu_rvalid = 1'b1; mmu_rdata = 32'h1234;
    step();
    mmu_rvalid = 1'b0; mmu_rdata = '0;
    repeat (5) step();
    chk("t6_rst_done", {30'd0, done1, done0}, 32'd0);
    chk("t6_rst_rdata0", rdata0, 32'd0);
    set1(1'b1, MMU_READ, 32'h800, 32'd0, 2'b11, 1'b0);
    rst_n = 1'b1;
    step();
    chk("t6_g0_vaddr", mmu_vaddr, 32'h700);
    mmu_resp(4, 32'h7777, MMU_NOERR);
    chk("t6_g0_done", {31'd0, done0}, 32'd1);
    chk("t6_g0_done1", {31'd0, done1}, 32'd0);
    req0 = 1'b0;
    step();
    chk("t6_g1_vaddr", mmu_vaddr, 32'h800);
    mmu_resp(4, 32'h8888, MMU_NOERR);
    chk("t6_g1_done", {31'd0, done1}, 32'd1);
    chk("t6_g1_rdata", rdata1, 32'h8888);
    req1 = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
